// File: rtl/mmio_arb_pkg.sv
// Shared types and defaults for the two-master MMIO bus arbiter.
package mmio_arb_pkg;

  // Bus ownership; OWN_NONE means no master is granted this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // Default cap on consecutive grant cycles while the other master waits.
  localparam int unsigned MAX_HOLD_DEFAULT = 4;

endpackage : mmio_arb_pkg

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for the shared MMIO data bus (ARM core on port 0,
// GPIO test port on port 1). Grants come from registered ownership state,
// handover between masters is bubble-free, and a hold counter bounds how
// long one master may keep the bus while the other is waiting.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata
);

  localparam int unsigned   HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;   // 1'b1: M1 was granted most recently
  logic [HW-1:0] hold_q, hold_d;
  logic          other_req_s;

  // State registers; reset drops ownership asynchronously so bus_we falls at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      hold_q  <= {HW{1'b0}};
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Next owner: tie from idle goes to the master not granted last; the
  // current owner is forced off when the waiting master hits the hold limit.
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OWN_NONE: begin
        if (m0_req && m1_req) begin
          owner_d = last_q ? OWN_M0 : OWN_M1;
        end else if (m0_req) begin
          owner_d = OWN_M0;
        end else if (m1_req) begin
          owner_d = OWN_M1;
        end else begin
          owner_d = OWN_NONE;
        end
      end
      OWN_M0: begin
        if (m0_req) begin
          if (m1_req && (hold_q == HOLD_LAST)) begin
            owner_d = OWN_M1;
          end else begin
            owner_d = OWN_M0;
          end
        end else if (m1_req) begin
          owner_d = OWN_M1;
        end else begin
          owner_d = OWN_NONE;
        end
      end
      OWN_M1: begin
        if (m1_req) begin
          if (m0_req && (hold_q == HOLD_LAST)) begin
            owner_d = OWN_M0;
          end else begin
            owner_d = OWN_M1;
          end
        end else if (m0_req) begin
          owner_d = OWN_M0;
        end else begin
          owner_d = OWN_NONE;
        end
      end
      default: owner_d = OWN_NONE;
    endcase
  end

  // Hold counter and last-granted tracking: count only cycles where the
  // other master is waiting, restart on every change of owner.
  always_comb begin
    case (owner_q)
      OWN_M0:  other_req_s = m1_req;
      OWN_M1:  other_req_s = m0_req;
      default: other_req_s = 1'b0;
    endcase

    if (owner_d != owner_q) begin
      hold_d = {HW{1'b0}};
    end else if (other_req_s && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
    end else begin
      hold_d = hold_q;
    end

    if (owner_d == OWN_M0) begin
      last_d = 1'b0;
    end else if (owner_d == OWN_M1) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  // Grants and bus mux decoded from registered ownership; a write needs
  // both the grant and the master's own request.
  always_comb begin
    m0_gnt   = (owner_q == OWN_M0);
    m1_gnt   = (owner_q == OWN_M1);
    m0_rdata = bus_rdata;
    m1_rdata = bus_rdata;
    case (owner_q)
      OWN_M0: begin
        bus_we    = m0_req & m0_we;
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
      end
      OWN_M1: begin
        bus_we    = m1_req & m1_we;
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
      end
      default: begin
        bus_we    = 1'b0;
        bus_addr  = {AW{1'b0}};
        bus_wdata = {DW{1'b0}};
      end
    endcase
  end

endmodule : mmio_bus_arbiter

// File: doc/mmio_bus_arbiter.md
# mmio_bus_arbiter

Two-master arbiter for the shared memory-mapped data bus that feeds dmem, LED, SPI and FPU chip-select decode. It replaces the compile-time CPU/testbench mux so the ARM core (port 0) and the GPIO test port (port 1) can share the bus at run time. Grants are registered, switching between masters costs no idle cycle, and a hold limit bounds how long one master can starve the other. Address decode and the read-data mux stay downstream; this block drives a single bus-side address, write-data and write-enable.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_HOLD, 4, maximum consecutive granted cycles for one master while the other is requesting; must be ≥1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  master requests the bus this cycle
- m0_we / m1_we  in  1  write strobe, qualified by the master's req and gnt
- m0_addr / m1_addr  in  AW  master address
- m0_wdata / m1_wdata  in  DW  master write data
- m0_gnt / m1_gnt  out  1  master owns the bus this cycle
- m0_rdata / m1_rdata  out  DW  read data; valid only while the matching gnt is high
- bus_we  out  1  write enable to the decode/chip-select logic
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_rdata  in  DW  read data returned from the downstream read mux

## Operation
- State register `owner` ∈ {OWN_NONE, OWN_M0, OWN_M1}. `m0_gnt = (owner==OWN_M0)` and `m1_gnt = (owner==OWN_M1)`; the grants are decoded from registered state only.
- Bus mux, combinational from `owner`:
  - OWN_M0: `bus_addr/bus_wdata = m0_*`; `bus_we = m0_req & m0_we`.
  - OWN_M1: same, from the m1 inputs.
  - OWN_NONE: addr and wdata are 0; `bus_we = 0`.
- An ungranted master never causes a write.
- `bus_rdata` fans out to both `m*_rdata` unchanged.
- `last` register records the most recently granted master. It resets to M1, so M0 wins the first tie.
- `hold` counter (width $clog2(MAX_HOLD+1)):
  - Clears on any change of `owner`.
  - Increments each cycle the owner is granted while the other master requests, saturating at MAX_HOLD.
  - Holds its value while the other master is idle.
- Next-state rules, evaluated at every clk edge:
  - From OWN_NONE: one requester → grant it. Both → grant the one that is not `last`. None → stay in OWN_NONE.
  - From OWN_Mx with own req high:
    - Other master idle → stay; no limit applies.
    - Other master requesting and `hold == MAX_HOLD-1` this cycle → switch to the other master.
    - Otherwise → stay.
  - From OWN_Mx with own req low: other master requesting → switch to it; otherwise → OWN_NONE.
- A master that drops req in the same cycle its grant was issued still had that cycle. Because its req is low, no write occurs.

## Timing
- Reset values: owner=OWN_NONE, last=M1, hold=0. All outputs are 0 during and immediately after reset; `m*_rdata` mirrors `bus_rdata`.
- Grant latency: req asserted in cycle N from OWN_NONE → gnt high in cycle N+1.
- Handover is zero-bubble. If the owner's last granted cycle is N and the other master is waiting, the other master is granted in N+1.
- Write commit: the downstream write happens on the clk edge that ends a cycle with `bus_we=1`. Each master must hold addr, wdata and we stable for as long as its req and gnt are both high.
- Read: combinational. `m*_rdata` is valid in the same cycle as gnt and addr.
- Masters must keep req high until they see gnt. The arbiter does not latch requests.
- Reset asserted mid-transaction: owner goes to OWN_NONE immediately and asynchronously, and `bus_we` drops the same instant. Any write in flight is lost.

## Structure
- Package `mmio_arb_pkg`: `owner_e` enum (OWN_NONE, OWN_M0, OWN_M1) and the `MAX_HOLD` default constant.
- Single module. The grant FSM, hold counter and output mux are small enough that no sub-module is natural.
- The top level instantiates this block between arm/GPIO and the chip-select decode.

## Test plan
- Reset then idle: hold reset 3 cycles with m0/m1 req=0 → both gnt stay 0, bus_we=0, bus_addr=0.
- Single master write: m1_req=1, we=1, addr=0x604, wdata=0xDEADBEEF at cycle N → m1_gnt=1 at N+1, bus_we=1, bus_addr=0x604 at N+1, write committed at the end of N+1.
- Simultaneous first request: m0_req and m1_req rise in the same cycle after reset → m0_gnt first; on handover m1_gnt follows with no OWN_NONE cycle.
- Hold limit: MAX_HOLD=4, m0 holds req continuously and m1 requests from cycle 2 onward → m0 gets exactly 4 grant cycles while m1 waits, then m1 is granted; alternation continues 4/4.
- Ungranted write blocked: m1 drives we=1, addr=0x500 while m0 owns the bus → bus_addr follows m0, and no write to 0x500 occurs until m1_gnt=1.
- Async reset mid-burst: assert reset between clk edges while m0 is granted with we=1 → m0_gnt and bus_we fall immediately, before the next edge; after release, m0 is re-granted one cycle after its next req.
